// File: rtl/decoder_4x16_sync.sv
// rtl/decoder_4x16_sync.sv - registered 4-to-16 one-hot decoder with enable and valid flag
// Optional build macro DECODER_4X16_HOLD_EN: enable low holds Y/valid instead of clearing them.
module decoder_4x16_sync (
  output logic [15:0] Y,
  input  logic [3:0]  I,
  input  logic        enable,
  input  logic        clk,
  input  logic        reset,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      Y     <= 16'h0000;
      valid <= 1'b0;
    end else if (enable) begin
      Y     <= 16'h0001 << I;
      valid <= 1'b1;
    end else begin
`ifdef DECODER_4X16_HOLD_EN
      // Idle cycles keep the last decode live until enable returns.
      Y     <= Y;
      valid <= valid;
`else
      Y     <= 16'h0000;
      valid <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_decoder_4x16_sync.sv
// tb/tb_decoder_4x16_sync.sv - scoreboard bench for decoder_4x16_sync (honours DECODER_4X16_HOLD_EN)
module tb_decoder_4x16_sync;

  logic [15:0] Y;
  logic [3:0]  I;
  logic        enable;
  logic        clk;
  logic        reset;
  logic        valid;

  typedef struct {
    logic [15:0] y;
    logic        v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  bit   driving_done = 0;

  logic [15:0] model_y = 16'h0000;
  logic        model_v = 1'b0;

  decoder_4x16_sync dut (
    .Y(Y),
    .I(I),
    .enable(enable),
    .clk(clk),
    .reset(reset),
    .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the selected output line is the power of two indexed by I.
  task automatic step(input logic r, input logic e, input int sel, input string tag);
    exp_t x;
    @(negedge clk);
    reset  = r;
    enable = e;
    I      = 4'(sel);
    if (r) begin
      model_y = 16'h0000;
      model_v = 1'b0;
    end else if (e) begin
      model_y = 16'(2 ** sel);
      model_v = 1'b1;
    end else begin
`ifndef DECODER_4X16_HOLD_EN
      model_y = 16'h0000;
      model_v = 1'b0;
`endif
    end
    x.y = model_y;
    x.v = model_v;
    x.tag = tag;
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      vectors++;
      if (Y !== x.y || valid !== x.v) begin
        miscompares++;
        $display("FAIL %s: got Y=%h valid=%b, expected Y=%h valid=%b", x.tag, Y, valid, x.y, x.v);
      end
      if (valid === 1'b1 && $countones(Y) != 1) begin
        miscompares++;
        $display("FAIL onehot_%s: got Y=%h with valid=1, expected exactly one bit set", x.tag, Y);
      end
`ifndef DECODER_4X16_HOLD_EN
      if (valid === 1'b0 && Y !== 16'h0000) begin
        miscompares++;
        $display("FAIL idle_zero_%s: got Y=%h with valid=0, expected 0000", x.tag, Y);
      end
`endif
    end
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    I      = 4'h0;

    step(1, 1, 5, "reset0");
    step(1, 1, 5, "reset1");
    step(0, 1, 5, "reset_release");

    for (int s = 0; s < 16; s++) step(0, 1, s, "sweep");

    step(0, 1, 15, "pre_disable");
    step(0, 0, 15, "disable");
    step(0, 0, 3, "disable_hold");

    for (int s = 0; s < 16; s++) step(0, 1, s, "wrap_up");
    step(0, 0, 15, "wrap_toggle_off");
    for (int s = 14; s >= 0; s--) step(0, 1, s, "wrap_down");
    step(0, 0, 0, "wrap_off_at0");
    step(0, 1, 0, "reenable_0");

    step(0, 1, 10, "mid_pre");
    step(1, 1, 10, "mid_reset");
    step(0, 1, 10, "mid_release");
    step(0, 0, 6, "reset_while_off_pre");
    step(1, 0, 6, "reset_while_off");
    step(0, 0, 6, "after_reset_off");

    for (int n = 0; n < 300; n++) begin
      logic r, e;
      r = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 3) != 0);
      step(r, e, $urandom_range(0, 15), "random");
    end

    driving_done = 1;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
